id_ex_alu_control: RTL and testbench

Decode-side producer of the execute-stage ALU control interface for the pipeline5 RV32I core. Decodes the instruction fields in the Decode stage, generates the 3-bit ALUControl encoding the execute ALU consumes together with the companion datapath controls, and registers them into the ID/EX pipeline stage with stall, flush and bubble handling. One clock; reset is synchronous and active-high.

---
 rtl/id_ex_alu_control.sv | 169 ++++++++++++++++
 tb/tb_id_ex_alu_control.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_control.sv
// id_ex_alu_control: decodes RV32I opcode/funct fields in the Decode stage
// into the ALU control bundle and registers it into the ID/EX stage with
// synchronous reset, flush (bubble insertion) and stall (hold) handling.
module id_ex_alu_control (
    input  logic       clk,
    input  logic       reset,
    input  logic       ValidD,
    input  logic [6:0] opD,
    input  logic [2:0] funct3D,
    input  logic [6:0] funct7D,
    input  logic       StallE,
    input  logic       FlushE,
    output logic [2:0] ImmSrcD,
    output logic       ValidE,
    output logic [2:0] ALUControlE,
    output logic       ALUSrcE,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic [1:0] ResultSrcE,
    output logic       BranchE,
    output logic       BranchNeE,
    output logic       JumpE,
    output logic       IllegalE
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef struct packed {
        logic       valid;
        alu_op_e    alu;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    // A bubble is the all-zero bundle: no enables, ADD, ALU result, invalid.
    localparam ctrl_t BUBBLE = '0;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    ctrl_t dec;
    logic  legal;

    // Immediate format selection: a pure function of the opcode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        ImmSrcD = 3'b000;
        case (opD)
            OP_SW:   ImmSrcD = 3'b001;
            OP_BR:   ImmSrcD = 3'b010;
            OP_JAL:  ImmSrcD = 3'b011;
            default: ImmSrcD = 3'b000;
        endcase
    end

    // Decode the D fields into the next ID/EX bundle (bubble when ValidD=0).
    always_comb begin
        dec   = BUBBLE;
        legal = 1'b0;
        case (opD)
            OP_R: begin
                dec.reg_write = 1'b1;
                if (funct7D == 7'b0000000) begin
                    legal = 1'b1;
                    case (funct3D)
                        3'b000:  dec.alu = ALU_ADD;
                        3'b010:  dec.alu = ALU_SLT;
                        3'b110:  dec.alu = ALU_OR;
                        3'b111:  dec.alu = ALU_AND;
                        default: legal = 1'b0;
                    endcase
                end else if (funct7D == 7'b0100000 && funct3D == 3'b000) begin
                    legal   = 1'b1;
                    dec.alu = ALU_SUB;
                end
            end
            OP_IALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                legal         = 1'b1;
                case (funct3D)
                    3'b000:  dec.alu = ALU_ADD;
                    3'b010:  dec.alu = ALU_SLT;
                    3'b110:  dec.alu = ALU_OR;
                    3'b111:  dec.alu = ALU_AND;
                    default: legal = 1'b0;
                endcase
            end
            OP_LW: begin
                legal          = (funct3D == 3'b010);
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
            end
            OP_SW: begin
                legal         = (funct3D == 3'b010);
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BR: begin
                legal         = (funct3D[2:1] == 2'b00);
                dec.alu       = ALU_SUB;
                dec.branch    = 1'b1;
                dec.branch_ne = funct3D[0];
            end
            OP_JAL: begin
                legal          = 1'b1;
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
            end
            default: legal = 1'b0;
        endcase

        if (!ValidD) begin
            ctrl_d = BUBBLE;
        end else if (legal) begin
            ctrl_d       = dec;
            ctrl_d.valid = 1'b1;
        end else begin
            // Unsupported encodings travel down the pipe with all enables off.
            ctrl_d         = BUBBLE;
            ctrl_d.valid   = 1'b1;
            ctrl_d.illegal = 1'b1;
        end
    end

    // ID/EX register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            ctrl_q <= BUBBLE;
        end else if (FlushE) begin
            ctrl_q <= BUBBLE;
        end else if (!StallE) begin
            ctrl_q <= ctrl_d;
        end
    end

    assign ValidE      = ctrl_q.valid;
    assign ALUControlE = ctrl_q.alu;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign ResultSrcE  = ctrl_q.result_src;
    assign BranchE     = ctrl_q.branch;
    assign BranchNeE   = ctrl_q.branch_ne;
    assign JumpE       = ctrl_q.jump;
    assign IllegalE    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_control.sv
// Testbench for id_ex_alu_control: fixed vector table, directed pipeline
// sequences (reset, stall, flush-over-stall) and randomized traffic checked
// against an encoding-table reference model.
module tb_id_ex_alu_control;

    logic       clk = 1'b0;
    logic       reset, ValidD, StallE, FlushE;
    logic [6:0] opD, funct7D;
    logic [2:0] funct3D;
    logic [2:0] ImmSrcD;
    logic       ValidE, ALUSrcE, RegWriteE, MemWriteE, BranchE, BranchNeE, JumpE, IllegalE;
    logic [2:0] ALUControlE;
    logic [1:0] ResultSrcE;

    int n_checks = 0;
    int n_fail   = 0;

    // Bundle bit order: {valid, alu[2:0], alusrc, regw, memw, res[1:0], br, brne, jmp, ill}
    localparam logic [12:0] E_ADD  = 13'b1_000_0_1_0_00_0_0_0_0;
    localparam logic [12:0] E_SUB  = 13'b1_001_0_1_0_00_0_0_0_0;
    localparam logic [12:0] E_SLT  = 13'b1_101_0_1_0_00_0_0_0_0;
    localparam logic [12:0] E_OR   = 13'b1_011_0_1_0_00_0_0_0_0;
    localparam logic [12:0] E_AND  = 13'b1_010_0_1_0_00_0_0_0_0;
    localparam logic [12:0] E_ADDI = 13'b1_000_1_1_0_00_0_0_0_0;
    localparam logic [12:0] E_SLTI = 13'b1_101_1_1_0_00_0_0_0_0;
    localparam logic [12:0] E_ORI  = 13'b1_011_1_1_0_00_0_0_0_0;
    localparam logic [12:0] E_ANDI = 13'b1_010_1_1_0_00_0_0_0_0;
    localparam logic [12:0] E_LW   = 13'b1_000_1_1_0_01_0_0_0_0;
    localparam logic [12:0] E_SW   = 13'b1_000_1_0_1_00_0_0_0_0;
    localparam logic [12:0] E_BEQ  = 13'b1_001_0_0_0_00_1_0_0_0;
    localparam logic [12:0] E_BNE  = 13'b1_001_0_0_0_00_1_1_0_0;
    localparam logic [12:0] E_JAL  = 13'b1_000_0_1_0_10_0_0_1_0;
    localparam logic [12:0] E_ILL  = 13'b1_000_0_0_0_00_0_0_0_1;
    localparam logic [12:0] E_BUB  = 13'b0;

    id_ex_alu_control dut (
        .clk(clk), .reset(reset), .ValidD(ValidD), .opD(opD), .funct3D(funct3D),
        .funct7D(funct7D), .StallE(StallE), .FlushE(FlushE), .ImmSrcD(ImmSrcD),
        .ValidE(ValidE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .BranchNeE(BranchNeE), .JumpE(JumpE), .IllegalE(IllegalE)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: table of legal encodings ----------------
    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f3_care;
        logic [6:0]  f7;
        logic        f7_care;
        logic [12:0] e;
    } enc_t;

    enc_t legal_tbl[14];

    function automatic logic [12:0] model_decode(input logic v, input logic [6:0] op,
                                                 input logic [2:0] f3, input logic [6:0] f7);
        if (!v) return E_BUB;
        for (int i = 0; i < 14; i++) begin
            if (legal_tbl[i].op == op &&
                (!legal_tbl[i].f3_care || legal_tbl[i].f3 == f3) &&
                (!legal_tbl[i].f7_care || legal_tbl[i].f7 == f7))
                return legal_tbl[i].e;
        end
        return E_ILL;
    endfunction

    function automatic logic [2:0] model_imm(input logic [6:0] op);
        if (op == 7'b0100011) return 3'b001;
        if (op == 7'b1100011) return 3'b010;
        if (op == 7'b1101111) return 3'b011;
        return 3'b000;
    endfunction

    function automatic logic [12:0] dut_e();
        return {ValidE, ALUControlE, ALUSrcE, RegWriteE, MemWriteE, ResultSrcE,
                BranchE, BranchNeE, JumpE, IllegalE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        ValidD = v; opD = op; funct3D = f3; funct7D = f7;
    endtask

    // ---------------- fixed vectors ----------------
    typedef struct packed {
        logic        v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [12:0] e;
        logic [2:0]  imm;
    } vec_t;

    vec_t vecs[18];

    initial begin
        legal_tbl[0]  = '{7'b0110011, 3'b000, 1'b1, 7'b0000000, 1'b1, E_ADD};
        legal_tbl[1]  = '{7'b0110011, 3'b000, 1'b1, 7'b0100000, 1'b1, E_SUB};
        legal_tbl[2]  = '{7'b0110011, 3'b010, 1'b1, 7'b0000000, 1'b1, E_SLT};
        legal_tbl[3]  = '{7'b0110011, 3'b110, 1'b1, 7'b0000000, 1'b1, E_OR};
        legal_tbl[4]  = '{7'b0110011, 3'b111, 1'b1, 7'b0000000, 1'b1, E_AND};
        legal_tbl[5]  = '{7'b0010011, 3'b000, 1'b1, 7'b0000000, 1'b0, E_ADDI};
        legal_tbl[6]  = '{7'b0010011, 3'b010, 1'b1, 7'b0000000, 1'b0, E_SLTI};
        legal_tbl[7]  = '{7'b0010011, 3'b110, 1'b1, 7'b0000000, 1'b0, E_ORI};
        legal_tbl[8]  = '{7'b0010011, 3'b111, 1'b1, 7'b0000000, 1'b0, E_ANDI};
        legal_tbl[9]  = '{7'b0000011, 3'b010, 1'b1, 7'b0000000, 1'b0, E_LW};
        legal_tbl[10] = '{7'b0100011, 3'b010, 1'b1, 7'b0000000, 1'b0, E_SW};
        legal_tbl[11] = '{7'b1100011, 3'b000, 1'b1, 7'b0000000, 1'b0, E_BEQ};
        legal_tbl[12] = '{7'b1100011, 3'b001, 1'b1, 7'b0000000, 1'b0, E_BNE};
        legal_tbl[13] = '{7'b1101111, 3'b000, 1'b0, 7'b0000000, 1'b0, E_JAL};

        vecs[0]  = '{1'b1, 7'b0110011, 3'b000, 7'b0100000, E_SUB,  3'b000};
        vecs[1]  = '{1'b1, 7'b0110011, 3'b010, 7'b0000000, E_SLT,  3'b000};
        vecs[2]  = '{1'b1, 7'b0110011, 3'b110, 7'b0000000, E_OR,   3'b000};
        vecs[3]  = '{1'b1, 7'b0110011, 3'b111, 7'b0000000, E_AND,  3'b000};
        vecs[4]  = '{1'b1, 7'b0110011, 3'b000, 7'b0000001, E_ILL,  3'b000};
        vecs[5]  = '{1'b1, 7'b0010011, 3'b000, 7'b1010101, E_ADDI, 3'b000};
        vecs[6]  = '{1'b1, 7'b0010011, 3'b010, 7'b0100000, E_SLTI, 3'b000};
        vecs[7]  = '{1'b1, 7'b0000011, 3'b010, 7'b0000000, E_LW,   3'b000};
        vecs[8]  = '{1'b1, 7'b0000011, 3'b000, 7'b0000000, E_ILL,  3'b000};
        vecs[9]  = '{1'b1, 7'b0100011, 3'b010, 7'b0000000, E_SW,   3'b001};
        vecs[10] = '{1'b1, 7'b1100011, 3'b001, 7'b0000000, E_BNE,  3'b010};
        vecs[11] = '{1'b1, 7'b1100011, 3'b000, 7'b0000000, E_BEQ,  3'b010};
        vecs[12] = '{1'b1, 7'b1100011, 3'b100, 7'b0000000, E_ILL,  3'b010};
        vecs[13] = '{1'b1, 7'b1101111, 3'b101, 7'b1111111, E_JAL,  3'b011};
        vecs[14] = '{1'b1, 7'b0110111, 3'b000, 7'b0000000, E_ILL,  3'b000};
        vecs[15] = '{1'b0, 7'b0100011, 3'b010, 7'b0000000, E_BUB,  3'b001};
        vecs[16] = '{1'b1, 7'b0110011, 3'b000, 7'b0000000, E_ADD,  3'b000};
        vecs[17] = '{1'b1, 7'b0010011, 3'b011, 7'b0000000, E_ILL,  3'b000};

        // ---- reset with stall asserted, then release ----
        reset = 1'b1; StallE = 1'b1; FlushE = 1'b0;
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        step();
        check("reset_bubble", 32'(dut_e()), 32'(E_BUB));
        step();
        check("reset_hold", 32'(dut_e()), 32'(E_BUB));
        reset = 1'b0; StallE = 1'b0;
        step();
        check("reset_release_add", 32'(dut_e()), 32'(E_ADD));
        check("reset_release_alu", 32'(ALUControlE), 32'h0);

        // ---- table sweep: ImmSrcD same cycle, E bundle one edge later ----
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].f3, vecs[i].f7);
            #1;
            check($sformatf("vec%0d_imm", i), 32'(ImmSrcD), 32'(vecs[i].imm));
            step();
            check($sformatf("vec%0d_e", i), 32'(dut_e()), 32'(vecs[i].e));
        end

        // ---- stall: sub held 3 cycles while D shows or ----
        drive(1'b1, 7'b0110011, 3'b000, 7'b0100000);
        step();
        check("stall_load_sub", 32'(dut_e()), 32'(E_SUB));
        StallE = 1'b1;
        drive(1'b1, 7'b0110011, 3'b110, 7'b0000000);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_hold%0d", i), 32'(dut_e()), 32'(E_SUB));
        end
        StallE = 1'b0;
        step();
        check("stall_release_or", 32'(dut_e()), 32'(E_OR));

        // ---- flush wins over stall with jal in E ----
        drive(1'b1, 7'b1101111, 3'b000, 7'b0000000);
        step();
        check("flush_load_jal", 32'(dut_e()), 32'(E_JAL));
        StallE = 1'b1; FlushE = 1'b1;
        step();
        check("flush_over_stall", 32'(dut_e()), 32'(E_BUB));
        StallE = 1'b0; FlushE = 1'b0;

        // ---- illegal instruction is stallable and flushable ----
        drive(1'b1, 7'b0110011, 3'b001, 7'b0000000);
        step();
        check("ill_load", 32'(dut_e()), 32'(E_ILL));
        StallE = 1'b1;
        drive(1'b1, 7'b0000011, 3'b010, 7'b0000000);
        step();
        check("ill_stall", 32'(dut_e()), 32'(E_ILL));
        StallE = 1'b0; FlushE = 1'b1;
        step();
        check("ill_flush", 32'(dut_e()), 32'(E_BUB));
        FlushE = 1'b0;

        // ---- reset mid-stream discards EX ----
        step();
        check("mid_load_lw", 32'(dut_e()), 32'(E_LW));
        reset = 1'b1;
        step();
        check("mid_reset", 32'(dut_e()), 32'(E_BUB));
        reset = 1'b0;

        // ---- randomized traffic vs reference model ----
        begin
            logic [12:0] exp_e;
            logic [6:0]  ops[7];
            ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100011, 7'b1101111, 7'b0000000};
            exp_e = E_BUB;
            for (int c = 0; c < 400; c++) begin
                logic [6:0] op, f7;
                logic [2:0] f3;
                logic       v;
                op = ops[$urandom_range(0, 6)];
                if (op == 7'b0000000) op = 7'($urandom);
                f3 = 3'($urandom);
                f7 = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20)
                                                 : 7'($urandom);
                v  = ($urandom_range(0, 7) != 0);
                drive(v, op, f3, f7);
                reset  = ($urandom_range(0, 31) == 0);
                FlushE = ($urandom_range(0, 7) == 0);
                StallE = ($urandom_range(0, 3) == 0);
                #1;
                check($sformatf("rnd%0d_imm", c), 32'(ImmSrcD), 32'(model_imm(op)));
                if (reset || FlushE)  exp_e = E_BUB;
                else if (!StallE)     exp_e = model_decode(v, op, f3, f7);
                step();
                check($sformatf("rnd%0d_e", c), 32'(dut_e()), 32'(exp_e));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
